// File: rtl/cmd_deframer.sv
// cmd_deframer
// Turns the SUMP host byte stream into whole commands for the analyzer core.
// Opcodes 0x00-0x7F are single-byte commands. Opcodes 0x80-0xFF are followed
// by four payload bytes, least significant byte first. If a long frame stalls
// for TMO cycles, the partial frame is thrown away. This keeps a lost byte from
// shifting every later command out of step.
//
// Ports
//   clk         system clock, single domain
//   rst         synchronous active-high reset
//   rxd_tvalid  host byte valid
//   rxd_tdata   host byte
//   rxd_tready  low only in the reset cycle; one byte per clock otherwise
//   cmd_valid   one-cycle pulse when cmd_code/cmd_data carry a new command
//   cmd_code    opcode of the last completed command
//   cmd_data    payload of the last completed command (0 for short ones)
//   err_tmo     one-cycle pulse when a stalled long frame is discarded
//   cmd_cnt     number of completed commands, wraps at 16 bits
module cmd_deframer #(
    parameter int TMO = 100000,
    parameter int TMW = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd_tvalid,
    input  logic [7:0]  rxd_tdata,
    output logic        rxd_tready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [31:0] cmd_data,
    output logic        err_tmo,
    output logic [15:0] cmd_cnt
);

    typedef enum logic {
        S_IDLE,
        S_DATA
    } state_t;

    localparam logic [TMW-1:0] TMO_LAST = TMW'(TMO - 1);

    state_t         r_state;
    state_t         w_stateNext;

    logic           r_ready;
    logic           r_cmdValid;
    logic [7:0]     r_cmdCode;
    logic [31:0]    r_cmdData;
    logic           r_errTmo;
    logic [15:0]    r_cmdCnt;

    logic [7:0]     r_opcode;
    logic [23:0]    r_asm;
    logic [1:0]     r_idx;
    logic [TMW-1:0] r_tmo;

    logic           w_accept;
    logic           w_emitShort;
    logic           w_loadOpcode;
    logic           w_storeByte;
    logic           w_emitLong;
    logic           w_timeout;

    assign w_accept = rxd_tvalid & r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Acceptance has priority over timeout expiry in DATA: a byte that lands
    // on the last allowed cycle still keeps the frame alive.
    always_comb begin
        w_stateNext  = r_state;
        w_emitShort  = 1'b0;
        w_loadOpcode = 1'b0;
        w_storeByte  = 1'b0;
        w_emitLong   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!rxd_tdata[7]) begin
                        w_emitShort = 1'b1;
                    end else begin
                        w_loadOpcode = 1'b1;
                        w_stateNext  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_storeByte = 1'b1;
                    if (r_idx == 2'd3) begin
                        w_emitLong  = 1'b1;
                        w_stateNext = S_IDLE;
                    end
                end else if (r_tmo == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Only the first three payload bytes are held in the assembly register.
    // The fourth byte goes straight into the top of cmd_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready    <= 1'b0;
            r_cmdValid <= 1'b0;
            r_cmdCode  <= 8'h00;
            r_cmdData  <= 32'h0;
            r_errTmo   <= 1'b0;
            r_cmdCnt   <= 16'h0;
            r_opcode   <= 8'h00;
            r_asm      <= 24'h0;
            r_idx      <= 2'd0;
            r_tmo      <= '0;
        end else begin
            r_ready    <= 1'b1;
            r_cmdValid <= w_emitShort | w_emitLong;
            r_errTmo   <= w_timeout;

            if (w_emitShort) begin
                r_cmdCode <= rxd_tdata;
                r_cmdData <= 32'h0;
                r_cmdCnt  <= r_cmdCnt + 16'd1;
            end

            if (w_loadOpcode) begin
                r_opcode <= rxd_tdata;
                r_idx    <= 2'd0;
                r_tmo    <= '0;
            end

            if (w_storeByte) begin
                case (r_idx)
                    2'd0:    r_asm[7:0]   <= rxd_tdata;
                    2'd1:    r_asm[15:8]  <= rxd_tdata;
                    2'd2:    r_asm[23:16] <= rxd_tdata;
                    default: ;
                endcase
                r_idx <= r_idx + 2'd1;
                r_tmo <= '0;
            end else if (r_state == S_DATA && r_tmo != TMO_LAST) begin
                // Saturates at TMO_LAST; leaving DATA makes wrapping moot anyway.
                r_tmo <= r_tmo + TMW'(1);
            end

            if (w_emitLong) begin
                r_cmdCode <= r_opcode;
                r_cmdData <= {rxd_tdata, r_asm};
                r_cmdCnt  <= r_cmdCnt + 16'd1;
            end
        end
    end

    assign rxd_tready = r_ready;
    assign cmd_valid  = r_cmdValid;
    assign cmd_code   = r_cmdCode;
    assign cmd_data   = r_cmdData;
    assign err_tmo    = r_errTmo;
    assign cmd_cnt    = r_cmdCnt;

endmodule

// File: tb/tb_cmd_deframer.sv
// tb_cmd_deframer
// Self-checking bench for cmd_deframer. The reference model tracks a pending
// frame as a byte queue plus a count of idle cycles since the last byte.
// A short TMO keeps the timeout scenarios brief.
module tb_cmd_deframer;

    localparam int TMO = 12;
    localparam int TMW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rxd_tvalid = 1'b0;
    logic [7:0]  rxd_tdata = 8'h00;
    logic        rxd_tready;
    logic        cmd_valid;
    logic [7:0]  cmd_code;
    logic [31:0] cmd_data;
    logic        err_tmo;
    logic [15:0] cmd_cnt;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model state
    logic        mReady = 1'b0;
    logic        mValid = 1'b0;
    logic        mErr = 1'b0;
    logic [7:0]  mCode = 8'h00;
    logic [31:0] mData = 32'h0;
    logic [15:0] mCnt = 16'h0;
    logic [7:0]  mFrame[$];
    int          mIdle = 0;

    cmd_deframer #(.TMO(TMO), .TMW(TMW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd_tvalid (rxd_tvalid),
        .rxd_tdata  (rxd_tdata),
        .rxd_tready (rxd_tready),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .cmd_data   (cmd_data),
        .err_tmo    (err_tmo),
        .cmd_cnt    (cmd_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // One clock of the command framing rules at byte/frame level.
    task automatic modelStep(input logic r, input logic acc, input logic [7:0] b);
        mValid = 1'b0;
        mErr   = 1'b0;
        if (r) begin
            mReady = 1'b0;
            mCode  = 8'h00;
            mData  = 32'h0;
            mCnt   = 16'h0;
            mFrame.delete();
            mIdle  = 0;
        end else begin
            mReady = 1'b1;
            if (mFrame.size() == 0) begin
                if (acc) begin
                    if (b < 8'h80) begin
                        mValid = 1'b1;
                        mCode  = b;
                        mData  = 32'h0;
                        mCnt   = mCnt + 16'd1;
                    end else begin
                        mFrame.push_back(b);
                        mIdle = 0;
                    end
                end
            end else if (acc) begin
                mFrame.push_back(b);
                mIdle = 0;
                if (mFrame.size() == 5) begin
                    mValid = 1'b1;
                    mCode  = mFrame[0];
                    mData  = {mFrame[4], mFrame[3], mFrame[2], mFrame[1]};
                    mCnt   = mCnt + 16'd1;
                    mFrame.delete();
                end
            end else begin
                mIdle++;
                if (mIdle == TMO) begin
                    mErr = 1'b1;
                    mFrame.delete();
                end
            end
        end
    endtask

    // Drives one cycle, advances the model and compares every output.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] b);
        logic acc;
        rst        = r;
        rxd_tvalid = v;
        rxd_tdata  = b;
        acc        = v & mReady & ~r;
        @(posedge clk);
        #1;
        modelStep(r, acc, b);
        checkOutput("ready", {31'h0, rxd_tready}, {31'h0, mReady});
        checkOutput("valid", {31'h0, cmd_valid},  {31'h0, mValid});
        checkOutput("err",   {31'h0, err_tmo},    {31'h0, mErr});
        checkOutput("code",  {24'h0, cmd_code},   {24'h0, mCode});
        checkOutput("data",  cmd_data,            mData);
        checkOutput("cnt",   {16'h0, cmd_cnt},    {16'h0, mCnt});
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, b);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 8'($urandom));
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'h85);
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        doReset();
        checkOutput("rst_ready", {31'h0, rxd_tready}, 32'd1);

        // Short command after reset
        sendByte(8'h02);
        checkOutput("t1_valid", {31'h0, cmd_valid}, 32'd1);
        checkOutput("t1_code",  {24'h0, cmd_code},  32'h02);
        checkOutput("t1_cnt",   {16'h0, cmd_cnt},   32'd1);
        idleCycles(1);
        checkOutput("t1_pulse", {31'h0, cmd_valid}, 32'd0);

        // Long command, consecutive bytes
        sendByte(8'hC0);
        sendByte(8'h11);
        sendByte(8'h22);
        sendByte(8'h33);
        checkOutput("t2_early", {31'h0, cmd_valid}, 32'd0);
        sendByte(8'h44);
        checkOutput("t2_valid", {31'h0, cmd_valid}, 32'd1);
        checkOutput("t2_code",  {24'h0, cmd_code},  32'hC0);
        checkOutput("t2_data",  cmd_data,           32'h44332211);

        // Stalled frame is dropped after TMO idle cycles
        sendByte(8'h80);
        sendByte(8'hAA);
        idleCycles(TMO - 1);
        checkOutput("t3_noerr", {31'h0, err_tmo}, 32'd0);
        idleCycles(1);
        checkOutput("t3_err",   {31'h0, err_tmo},   32'd1);
        checkOutput("t3_noval", {31'h0, cmd_valid}, 32'd0);
        checkOutput("t3_keep",  {24'h0, cmd_code},  32'hC0);
        sendByte(8'h11);
        checkOutput("t3_code", {24'h0, cmd_code}, 32'h11);
        checkOutput("t3_data", cmd_data,          32'h0);

        // Byte arrives exactly on the expiry cycle
        sendByte(8'h80);
        sendByte(8'h01);
        sendByte(8'h02);
        idleCycles(TMO - 1);
        sendByte(8'h03);
        checkOutput("t4_noerr", {31'h0, err_tmo}, 32'd0);
        sendByte(8'h04);
        checkOutput("t4_valid", {31'h0, cmd_valid}, 32'd1);
        checkOutput("t4_data",  cmd_data,           32'h04030201);

        // Back-to-back short commands
        doReset();
        for (int i = 0; i < 5; i++) begin
            sendByte(8'h00);
            checkOutput("t5_valid", {31'h0, cmd_valid}, 32'd1);
        end
        checkOutput("t5_cnt", {16'h0, cmd_cnt}, 32'd5);

        // Reset mid-frame loses the partial frame
        sendByte(8'h81);
        sendByte(8'h01);
        sendByte(8'h02);
        doReset();
        sendByte(8'h05);
        checkOutput("t6_code", {24'h0, cmd_code}, 32'h05);
        checkOutput("t6_cnt",  {16'h0, cmd_cnt},  32'd1);
        checkOutput("t6_data", cmd_data,          32'h0);

        // Randomized traffic: mixed opcodes, gaps near the timeout, rare resets
        for (int i = 0; i < 3000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel == 0) begin
                doReset();
            end else if (sel < 5) begin
                idleCycles(int'($urandom_range(TMO - 2, TMO + 2)));
            end else if (sel < 70) begin
                sendByte(8'($urandom));
            end else begin
                applyStimulus(1'b0, 1'b0, 8'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
